// File: rtl/moore_counter_pkg.sv
// Shared definitions for the Moore up/down counter: direction encoding and the
// load clamp helper that keeps loaded values inside the count range.
package moore_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Out-of-range load values pin to the top of the range rather than aliasing.
    function automatic int unsigned clamp_load(input int unsigned value,
                                               input int unsigned modulus);
        return (value < modulus) ? value : (modulus - 1);
    endfunction

endpackage

// File: rtl/moore_updown_counter.sv
// WIDTH-bit modulo-MODULUS up/down counter with load, Moore terminal-count flag
// and registered wrap pulse. Define MOORE_COUNTER_SATURATE_EN to saturate instead of wrap.
module moore_updown_counter
    import moore_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             y_out,
    output logic             wrap
);

    // The load clamp works in 32-bit arithmetic, so WIDTH is bounded to 32 as well.
    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
        64'(MODULUS) > (64'd1 << WIDTH)) begin : g_param_check
        $error("moore_updown_counter: illegal WIDTH/MODULUS combination");
    end

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_count_next;
    logic             w_wrap_next;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MODULUS)));

    always_comb begin
        w_count_next = r_count;
        w_wrap_next  = 1'b0;
        if (load) begin
            w_count_next = w_load_clamped;
        end else if (en) begin
            if (up == DIR_UP) begin
                if (r_count == LP_MAX) begin
`ifdef MOORE_COUNTER_SATURATE_EN
                    w_count_next = LP_MAX;
`else
                    w_count_next = '0;
                    w_wrap_next  = 1'b1;
`endif
                end else begin
                    w_count_next = r_count + WIDTH'(1);
                end
            end else begin
                if (r_count == '0) begin
`ifdef MOORE_COUNTER_SATURATE_EN
                    w_count_next = '0;
`else
                    w_count_next = LP_MAX;
                    w_wrap_next  = 1'b1;
`endif
                end else begin
                    w_count_next = r_count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_wrap  <= w_wrap_next;
        end
    end

    // Terminal count is decoded from the state register alone.
    assign count = r_count;
    assign y_out = (r_count == LP_MAX);
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_moore_updown_counter.sv
// Directed plus randomized bench for moore_updown_counter (WIDTH=4, MODULUS=10)
// against an arithmetic reference model; honours MOORE_COUNTER_SATURATE_EN.
module tb_moore_updown_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         y_out;
    logic         wrap;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_count = 0;
    bit m_wrap  = 1'b0;

    moore_updown_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .y_out    (y_out),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_count = 0;
        m_wrap  = 1'b0;
    endtask

    task automatic model_edge(input bit l, input bit e, input bit u, input int v);
        m_wrap = 1'b0;
        if (l) begin
            m_count = (v < M) ? v : M - 1;
        end else if (e) begin
`ifdef MOORE_COUNTER_SATURATE_EN
            if (u) m_count = (m_count + 1 > M - 1) ? M - 1 : m_count + 1;
            else   m_count = (m_count - 1 < 0) ? 0 : m_count - 1;
`else
            if (u) begin
                m_wrap  = (m_count + 1 >= M);
                m_count = (m_count + 1) % M;
            end else begin
                m_wrap  = (m_count == 0);
                m_count = (m_count + M - 1) % M;
            end
`endif
        end
    endtask

    task automatic check(input string tag);
        logic [W-1:0] exp_c;
        logic         exp_y;
        logic         exp_w;
        exp_c = W'(m_count);
        exp_y = (m_count == M - 1);
        exp_w = m_wrap;
        n_cmp++;
        assert (count === exp_c) else begin
            n_fail++;
            $error("FAIL %s count got %0d exp %0d", tag, count, exp_c);
        end
        n_cmp++;
        assert (y_out === exp_y) else begin
            n_fail++;
            $error("FAIL %s y_out got %b exp %b", tag, y_out, exp_y);
        end
        n_cmp++;
        assert (wrap === exp_w) else begin
            n_fail++;
            $error("FAIL %s wrap got %b exp %b", tag, wrap, exp_w);
        end
        $display("%s: load=%b en=%b up=%b val=%0d -> count=%0d y_out=%b wrap=%b",
                 tag, load, en, up, load_val, count, y_out, wrap);
    endtask

    task automatic step(input string tag, input bit l, input bit e, input bit u, input int v);
        load     = l;
        en       = e;
        up       = u;
        load_val = W'(v);
        @(posedge clk);
        model_edge(l, e, u, v);
        #1;
        check(tag);
    endtask

    initial begin
        // Reset held for three clocks
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold");
        end
        rstn = 1'b1;

        for (int i = 0; i < 11; i++) step("up_wrap", 0, 1, 1, 0);

        step("down_load", 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("down_wrap", 0, 1, 0, 0);

        step("load_clamp", 1, 1, 1, 12);
        step("load_3", 1, 0, 0, 3);
        step("load_15", 1, 0, 1, 15);

        step("load_5", 1, 0, 0, 5);
        for (int i = 0; i < 4; i++) step("hold", 0, 0, i[0], 0);
        // Inputs changing between edges must not move the Moore outputs
        load = 1'b1; load_val = 4'd9; en = 1'b1; up = 1'b1;
        #2;
        check("moore_no_comb");
        for (int i = 0; i < 4; i++) step("dir_flip", 0, 1, ~i[0], 0);

        step("sat_load8", 1, 0, 0, 8);
        for (int i = 0; i < 4; i++) step("sat_up", 0, 1, 1, 0);
        step("sat_load1", 1, 0, 0, 1);
        for (int i = 0; i < 2; i++) step("sat_down", 0, 1, 0, 0);

        step("pre_rst_load", 1, 0, 0, 4);
        step("pre_rst_up", 0, 1, 1, 0);
        step("pre_rst_up", 0, 1, 1, 0);
        // Asynchronous reset mid-cycle at count=6
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check("async_reset");
        @(posedge clk);
        #1;
        check("async_reset_held");
        en = 1'b0; load = 1'b0;
        rstn = 1'b1;

        for (int i = 0; i < 300; i++) begin
            step("random", ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), int'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
